// File: rtl/pattern_pkg.sv
// Shared defaults, serial-load FSM state type and flat byte indexing for the pattern bank.
package pattern_pkg;

    localparam int DEF_NO_BUFS   = 8;
    localparam int DEF_BUF_SIZE  = 12;
    localparam int DEF_BUF_WIDTH = 8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } serial_state_e;

    function automatic int byte_lsb(input int k, input int width = DEF_BUF_WIDTH);
        return k * width;
    endfunction

endpackage

// File: rtl/pattern_bank_entry.sv
// One pattern buffer: serially loaded shadow chain plus the active copy seen by the datapath.
module pattern_bank_entry
    import pattern_pkg::*;
#(
    parameter int BUF_SIZE  = DEF_BUF_SIZE,
    parameter int BUF_WIDTH = DEF_BUF_WIDTH,
    parameter int FW        = $clog2(BUF_SIZE)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_shift,
    input  logic                          i_sin,
    output logic                          o_msb,
    input  logic                          i_copy,
    input  logic                          i_wr_en,
    input  logic [FW-1:0]                 i_wr_idx,
    input  logic [BUF_WIDTH-1:0]          i_wr_data,
    output logic [BUF_SIZE*BUF_WIDTH-1:0] o_active
);

    localparam int L = BUF_SIZE * BUF_WIDTH;

    logic [L-1:0] r_shadow;
    logic [L-1:0] r_active;
    logic [L-1:0] w_active_next;

    // A field write lands on top of a same-cycle copy so the written byte survives.
    always_comb begin
        w_active_next = r_active;
        if (i_copy)
            w_active_next = r_shadow;
        if (i_wr_en)
            w_active_next[byte_lsb(int'(i_wr_idx), BUF_WIDTH) +: BUF_WIDTH] = i_wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow <= '0;
            r_active <= '0;
        end else begin
            if (i_shift)
                r_shadow <= {r_shadow[L-2:0], i_sin};
            r_active <= w_active_next;
        end
    end

    assign o_msb    = r_shadow[L-1];
    assign o_active = r_active;

endmodule

// File: rtl/pattern_bank.sv
// Double-buffered pattern bank: serial load FSM, commit handshake with deferral, registered views.
module pattern_bank
    import pattern_pkg::*;
#(
    parameter int NO_BUFS   = DEF_NO_BUFS,
    parameter int BUF_SIZE  = DEF_BUF_SIZE,
    parameter int BUF_WIDTH = DEF_BUF_WIDTH,
    parameter int SW        = $clog2(NO_BUFS),
    parameter int FW        = $clog2(BUF_SIZE)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          s_en,
    input  logic                          sin,
    input  logic [SW-1:0]                 saddr,
    output logic                          sout,
    output logic                          load_done,
    input  logic                          commit,
    input  logic [SW-1:0]                 commit_sel,
    output logic                          commit_ack,
    input  logic [SW-1:0]                 buffer_select,
    output logic [BUF_SIZE*BUF_WIDTH-1:0] current_buffer,
    input  logic [SW-1:0]                 bufp,
    input  logic [FW-1:0]                 fieldp,
    output logic [BUF_WIDTH-1:0]          field_byte,
    input  logic [FW-1:0]                 fieldwp,
    input  logic [BUF_WIDTH-1:0]          field_in,
    input  logic                          field_write
);

    localparam int L  = BUF_SIZE * BUF_WIDTH;
    localparam int CW = $clog2(L + 1);

    serial_state_e  r_state, w_state_next;
    logic [CW-1:0]  r_cnt, w_cnt_next;
    logic [SW-1:0]  r_saddr, r_pend_sel;
    logic           r_pending, r_load_done, r_commit_ack, r_sout;
    logic [L-1:0]   r_cur;
    logic [BUF_WIDTH-1:0] r_field;

    logic               w_done, w_defer, w_set_pending, w_ack;
    logic               w_wr_ok, w_rd_ok;
    logic [FW-1:0]      w_wr_idx, w_rd_idx;
    logic [NO_BUFS-1:0] w_copy, w_wr_en, w_msb;
    logic [L-1:0]       w_active [NO_BUFS];

    for (genvar g = 0; g < NO_BUFS; g++) begin : g_buf
        pattern_bank_entry #(
            .BUF_SIZE  (BUF_SIZE),
            .BUF_WIDTH (BUF_WIDTH),
            .FW        (FW)
        ) u_entry (
            .clk       (clk),
            .reset     (reset),
            .i_shift   (s_en && (saddr == SW'(g))),
            .i_sin     (sin),
            .o_msb     (w_msb[g]),
            .i_copy    (w_copy[g]),
            .i_wr_en   (w_wr_en[g]),
            .i_wr_idx  (w_wr_idx),
            .i_wr_data (field_in),
            .o_active  (w_active[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_saddr <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_saddr <= saddr;
        end
    end

    // A change of saddr mid-load restarts the count; the old shadow keeps what it already got.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (s_en) begin
                    w_state_next = S_SHIFT;
                    w_cnt_next   = CW'(1);
                end
            end
            S_SHIFT: begin
                if (saddr != r_saddr)
                    w_cnt_next = s_en ? CW'(1) : '0;
                else if (w_done) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else if (s_en)
                    w_cnt_next = r_cnt + 1'b1;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_done        = (r_state == S_SHIFT) && s_en && (saddr == r_saddr) && (r_cnt == CW'(L - 1));
        w_defer       = (r_state == S_SHIFT) && (commit_sel == r_saddr);
        w_copy        = '0;
        w_ack         = 1'b0;
        w_set_pending = 1'b0;
        if (r_load_done && r_pending) begin
            w_copy[r_pend_sel] = 1'b1;
            w_ack              = 1'b1;
        end
        if (commit && !r_pending) begin
            if (w_defer)
                w_set_pending = 1'b1;
            else begin
                w_copy[commit_sel] = 1'b1;
                w_ack              = 1'b1;
            end
        end
        w_wr_ok  = int'(fieldwp) < BUF_SIZE;
        w_rd_ok  = int'(fieldp) < BUF_SIZE;
        w_wr_idx = w_wr_ok ? fieldwp : '0;
        w_rd_idx = w_rd_ok ? fieldp : '0;
        for (int b = 0; b < NO_BUFS; b++)
            w_wr_en[b] = field_write && w_wr_ok && (bufp == SW'(b));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_load_done  <= 1'b0;
            r_commit_ack <= 1'b0;
            r_pending    <= 1'b0;
            r_pend_sel   <= '0;
            r_sout       <= 1'b0;
            r_cur        <= '0;
            r_field      <= '0;
        end else begin
            r_load_done  <= w_done;
            r_commit_ack <= w_ack;
            if (w_set_pending) begin
                r_pending  <= 1'b1;
                r_pend_sel <= commit_sel;
            end else if (r_load_done)
                r_pending <= 1'b0;
            if (s_en)
                r_sout <= w_msb[saddr];
            r_cur   <= w_active[buffer_select];
            r_field <= w_rd_ok ? w_active[bufp][byte_lsb(int'(w_rd_idx), BUF_WIDTH) +: BUF_WIDTH] : '0;
        end
    end

    assign sout           = r_sout;
    assign load_done      = r_load_done;
    assign commit_ack     = r_commit_ack;
    assign current_buffer = r_cur;
    assign field_byte     = r_field;

endmodule

// File: tb/tb_pattern_bank.sv
// Directed bench for pattern_bank: reset, serial load/commit, deferred commit, field port, collisions.
module tb_pattern_bank;

    localparam int NB = 8;
    localparam int BS = 12;
    localparam int BW = 8;
    localparam int SW = 3;
    localparam int FW = 4;
    localparam int L  = BS * BW;

    logic          clk = 1'b0;
    logic          reset, s_en, sin, commit, field_write;
    logic [SW-1:0] saddr, commit_sel, buffer_select, bufp;
    logic [FW-1:0] fieldp, fieldwp;
    logic [BW-1:0] field_in, field_byte;
    logic          sout, load_done, commit_ack;
    logic [L-1:0]  current_buffer;

    int nCompared   = 0;
    int nMismatched = 0;
    int d, a;

    pattern_bank #(.NO_BUFS(NB), .BUF_SIZE(BS), .BUF_WIDTH(BW)) dut (
        .clk(clk), .reset(reset), .s_en(s_en), .sin(sin), .saddr(saddr), .sout(sout),
        .load_done(load_done), .commit(commit), .commit_sel(commit_sel), .commit_ack(commit_ack),
        .buffer_select(buffer_select), .current_buffer(current_buffer), .bufp(bufp),
        .fieldp(fieldp), .field_byte(field_byte), .fieldwp(fieldwp), .field_in(field_in),
        .field_write(field_write)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shifts n bits of v MSB-first starting at bit offset start; reports the shift index that
    // produced load_done (0 if none) and how many commit_ack pulses were seen meanwhile.
    task automatic shift_vec(input logic [L-1:0] v, input int start, input int n,
                             output int doneAt, output int ackCount);
        doneAt   = 0;
        ackCount = 0;
        for (int i = 0; i < n; i++) begin
            s_en = 1'b1;
            sin  = v[L-1-start-i];
            tick();
            if (load_done === 1'b1 && doneAt == 0) doneAt = i + 1;
            if (commit_ack === 1'b1) ackCount++;
        end
        s_en = 1'b0;
        sin  = 1'b0;
    endtask

    task automatic test_reset();
        logic [L-1:0] ones;
        ones = '1;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        saddr = 3'd0;
        shift_vec(ones, 0, 40, d, a);
        commit = 1'b1; commit_sel = 3'd0;
        tick();
        commit = 1'b0;
        reset = 1'b1; s_en = 1'b1; sin = 1'b1;
        tick(); tick();
        reset = 1'b0; s_en = 1'b0; sin = 1'b0;
        nCompared++; if (current_buffer !== '0) begin nMismatched++; $display("[TB] FAIL reset_current_buffer: got %h expected 0", current_buffer); end
        nCompared++; if (field_byte !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_field_byte: got %h expected 00", field_byte); end
        nCompared++; if (sout !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_sout: got %b expected 0", sout); end
        nCompared++; if (load_done !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_load_done: got %b expected 0", load_done); end
        nCompared++; if (commit_ack !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_commit_ack: got %b expected 0", commit_ack); end
        for (int b = 0; b < NB; b++) begin
            for (int k = 0; k < BS; k++) begin
                bufp = SW'(b); fieldp = FW'(k);
                tick();
                nCompared++; if (field_byte !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_field_read buf %0d byte %0d: got %h expected 00", b, k, field_byte); end
            end
        end
        shift_vec('0, 0, L, d, a);
        nCompared++; if (d != L) begin nMismatched++; $display("[TB] FAIL reset_full_load: done at shift %0d expected %0d", d, L); end
        tick();
        nCompared++; if (commit_ack !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_pending_cleared: ack %b expected 0", commit_ack); end
        nCompared++; if (load_done !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_done_pulse_width: got %b expected 0", load_done); end
    endtask

    task automatic test_load_commit();
        logic [L-1:0] p;
        p = 96'hA5010203_04050607_08090A0B;
        saddr = 3'd3; buffer_select = 3'd3;
        shift_vec(p, 0, L, d, a);
        nCompared++; if (d != L) begin nMismatched++; $display("[TB] FAIL load_done_cycle: done at %0d expected %0d", d, L); end
        nCompared++; if (current_buffer !== '0) begin nMismatched++; $display("[TB] FAIL load_precommit_view: got %h expected 0", current_buffer); end
        commit = 1'b1; commit_sel = 3'd3;
        tick();
        commit = 1'b0;
        nCompared++; if (commit_ack !== 1'b1) begin nMismatched++; $display("[TB] FAIL commit_ack_latency: got %b expected 1", commit_ack); end
        nCompared++; if (current_buffer !== '0) begin nMismatched++; $display("[TB] FAIL commit_view_latency: got %h expected 0", current_buffer); end
        tick();
        nCompared++; if (commit_ack !== 1'b0) begin nMismatched++; $display("[TB] FAIL commit_ack_width: got %b expected 0", commit_ack); end
        nCompared++; if (current_buffer !== p) begin nMismatched++; $display("[TB] FAIL commit_view: got %h expected %h", current_buffer, p); end
        nCompared++; if (current_buffer[95:88] !== 8'hA5) begin nMismatched++; $display("[TB] FAIL commit_byte11: got %h expected a5", current_buffer[95:88]); end
        s_en = 1'b1; sin = 1'b0;
        tick();
        nCompared++; if (sout !== 1'b1) begin nMismatched++; $display("[TB] FAIL sout_bit0: got %b expected 1", sout); end
        tick();
        s_en = 1'b0;
        nCompared++; if (sout !== 1'b0) begin nMismatched++; $display("[TB] FAIL sout_bit1: got %b expected 0", sout); end
    endtask

    task automatic test_deferred();
        logic [L-1:0] q;
        q = 96'h01234567_89ABCDEF_FEDCBA98;
        saddr = 3'd5; buffer_select = 3'd5;
        shift_vec(q, 0, 39, d, a);
        s_en = 1'b1; sin = q[L-40]; commit = 1'b1; commit_sel = 3'd5;
        tick();
        s_en = 1'b0; commit = 1'b0;
        nCompared++; if (commit_ack !== 1'b0) begin nMismatched++; $display("[TB] FAIL defer_no_ack: got %b expected 0", commit_ack); end
        shift_vec(q, 40, 20, d, a);
        nCompared++; if (a != 0) begin nMismatched++; $display("[TB] FAIL defer_ack_during_load: got %0d acks expected 0", a); end
        commit = 1'b1; commit_sel = 3'd5;
        tick();
        commit = 1'b0;
        nCompared++; if (commit_ack !== 1'b0) begin nMismatched++; $display("[TB] FAIL defer_second_commit: ack %b expected 0", commit_ack); end
        shift_vec(q, 60, 36, d, a);
        nCompared++; if (d != 36) begin nMismatched++; $display("[TB] FAIL defer_done: at %0d expected 36", d); end
        nCompared++; if (a != 0) begin nMismatched++; $display("[TB] FAIL defer_early_ack: got %0d acks expected 0", a); end
        tick();
        nCompared++; if (commit_ack !== 1'b1) begin nMismatched++; $display("[TB] FAIL defer_ack: got %b expected 1", commit_ack); end
        tick();
        nCompared++; if (commit_ack !== 1'b0) begin nMismatched++; $display("[TB] FAIL defer_extra_ack: got %b expected 0", commit_ack); end
        nCompared++; if (current_buffer !== q) begin nMismatched++; $display("[TB] FAIL defer_view: got %h expected %h", current_buffer, q); end
    endtask

    task automatic test_field();
        bufp = 3'd2; fieldwp = 4'd0; field_in = 8'h5A; field_write = 1'b1;
        tick();
        fieldwp = 4'd7; field_in = 8'h3C;
        tick();
        field_write = 1'b0; fieldp = 4'd7;
        tick();
        nCompared++; if (field_byte !== 8'h3C) begin nMismatched++; $display("[TB] FAIL field_read: got %h expected 3c", field_byte); end
        field_write = 1'b1; field_in = 8'h99;
        tick();
        field_write = 1'b0;
        nCompared++; if (field_byte !== 8'h3C) begin nMismatched++; $display("[TB] FAIL field_rdw_old: got %h expected 3c", field_byte); end
        tick();
        nCompared++; if (field_byte !== 8'h99) begin nMismatched++; $display("[TB] FAIL field_rdw_new: got %h expected 99", field_byte); end
        fieldp = 4'd12;
        tick();
        nCompared++; if (field_byte !== 8'h00) begin nMismatched++; $display("[TB] FAIL field_read_oob: got %h expected 00", field_byte); end
        fieldp = 4'd0; fieldwp = 4'd12; field_in = 8'hEE; field_write = 1'b1;
        tick();
        field_write = 1'b0;
        tick();
        nCompared++; if (field_byte !== 8'h5A) begin nMismatched++; $display("[TB] FAIL field_write_oob: byte0 %h expected 5a", field_byte); end
    endtask

    task automatic test_collision();
        logic [L-1:0] r;
        logic [L-1:0] expv;
        r = 96'hDEADBEEF_CAFEF00D_13579BDF;
        expv = {r[L-1:8], 8'h77};
        saddr = 3'd1;
        shift_vec(r, 0, L, d, a);
        nCompared++; if (d != L) begin nMismatched++; $display("[TB] FAIL collide_load: done at %0d expected %0d", d, L); end
        commit = 1'b1; commit_sel = 3'd1; buffer_select = 3'd1;
        field_write = 1'b1; bufp = 3'd1; fieldwp = 4'd0; field_in = 8'h77;
        tick();
        commit = 1'b0; field_write = 1'b0;
        nCompared++; if (commit_ack !== 1'b1) begin nMismatched++; $display("[TB] FAIL collide_ack: got %b expected 1", commit_ack); end
        tick();
        nCompared++; if (current_buffer !== expv) begin nMismatched++; $display("[TB] FAIL collide_view: got %h expected %h", current_buffer, expv); end
    endtask

    task automatic test_saddr_switch();
        logic [L-1:0] s;
        logic [L-1:0] t;
        logic [L-1:0] expv;
        s = 96'hB7E15163_00000000_00000000;
        t = 96'h243F6A88_85A308D3_13198A2E;
        expv = '0;
        expv[29:0] = s[L-1:L-30];
        saddr = 3'd2;
        shift_vec(s, 0, 30, d, a);
        nCompared++; if (d != 0) begin nMismatched++; $display("[TB] FAIL switch_partial_done: at %0d expected 0", d); end
        saddr = 3'd4;
        shift_vec(t, 0, L, d, a);
        nCompared++; if (d != L) begin nMismatched++; $display("[TB] FAIL switch_done: at %0d expected %0d", d, L); end
        commit = 1'b1; commit_sel = 3'd2; buffer_select = 3'd2;
        tick();
        commit = 1'b0;
        tick();
        nCompared++; if (current_buffer !== expv) begin nMismatched++; $display("[TB] FAIL switch_old_shadow: got %h expected %h", current_buffer, expv); end
        commit = 1'b1; commit_sel = 3'd4; buffer_select = 3'd4;
        tick();
        commit = 1'b0;
        tick();
        nCompared++; if (current_buffer !== t) begin nMismatched++; $display("[TB] FAIL switch_new_shadow: got %h expected %h", current_buffer, t); end
    endtask

    initial begin
        reset = 1'b1; s_en = 1'b0; sin = 1'b0; saddr = '0;
        commit = 1'b0; commit_sel = '0; buffer_select = '0;
        bufp = '0; fieldp = '0; fieldwp = '0; field_in = '0; field_write = 1'b0;
        test_reset();
        test_load_commit();
        test_deferred();
        test_field();
        test_collision();
        test_saddr_switch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/pattern_bank.md
Name: pattern_bank

Overview:
- Parametrised, double-buffered successor to the 8-way pattern buffer bank. Holds NO_BUFS pattern buffers of BUF_SIZE bytes, each BUF_WIDTH bits wide.
- Each buffer has a shadow copy loaded serially and an active copy seen by the datapath. A commit handshake swaps shadow to active, so patterns reload without glitching the running sequence.
- Sits between the serial config interface and the sequencer/field datapath. Provides a registered current-buffer view and a registered field byte port.

Parameters:
- NO_BUFS, 8, number of buffers; power of 2, 2..16.
- BUF_SIZE, 12, bytes per buffer.
- BUF_WIDTH, 8, bits per byte.
- SW, $clog2(NO_BUFS), buffer select width (derived).
- FW, $clog2(BUF_SIZE), field pointer width (derived).

Ports:
- clk  in  1  single system clock.
- reset  in  1  synchronous, active-high.
- s_en  in  1  serial shift strobe; one bit shifted per cycle while high.
- sin  in  1  serial data in.
- saddr  in  SW  buffer targeted by serial load.
- sout  out  1  serial data out of the targeted shadow chain.
- load_done  out  1  one-cycle pulse when a full chain has been shifted.
- commit  in  1  request shadow→active copy for commit_sel.
- commit_sel  in  SW  buffer to commit.
- commit_ack  out  1  one-cycle pulse when the copy is performed.
- buffer_select  in  SW  buffer shown on current_buffer.
- current_buffer  out  BUF_SIZE*BUF_WIDTH  active contents of buffer_select, flat; byte k at [k*BUF_WIDTH +: BUF_WIDTH].
- bufp  in  SW  buffer for field access.
- fieldp  in  FW  field read byte index.
- field_byte  out  BUF_WIDTH  active[bufp][fieldp].
- fieldwp  in  FW  field write byte index.
- field_in  in  BUF_WIDTH  field write data.
- field_write  in  1  write field_in to active[bufp][fieldwp].

Behaviour:
- Reset: all shadow and active arrays 0; current_buffer, field_byte, sout, load_done and commit_ack all 0; serial FSM in IDLE; bit counter 0; commit pending flag cleared.
- Reset mid-shift or mid-commit abandons the operation. No ack or done pulse is issued.
- Serial chain (L = BUF_SIZE*BUF_WIDTH bits):
  - On an s_en cycle, shadow[saddr] <= {shadow[saddr][L-2:0], sin}.
  - sout is registered: it holds the bit shifted out of position L-1 on the last s_en cycle. It is 0 after reset.
  - The first bit shifted in ends at byte BUF_SIZE-1, bit BUF_WIDTH-1 after L shifts.
- Serial FSM (IDLE, SHIFT):
  - IDLE→SHIFT on the first s_en; the counter becomes 1.
  - In SHIFT, each s_en increments the counter. s_en low holds the state.
  - When the counter reaches L, load_done pulses for one cycle and the FSM returns to IDLE with the counter at 0.
  - saddr changing while in SHIFT restarts the counter at 0 (or at 1 if s_en is high that cycle). Bits already shifted remain in the old shadow.
- Commit:
  - commit high in a cycle: the copy happens at the next clock edge and commit_ack pulses in the following cycle (1-cycle latency).
  - If commit_sel equals the buffer currently in SHIFT, the commit is deferred: the pending flag is set, and the copy plus ack occur in the cycle after load_done.
  - Only one pending commit is held. A second commit while pending is ignored and produces no ack.
  - Commit and field_write to the same buffer in the same cycle: copy first, then the write is applied on top, so the written byte survives.
- Field write: takes effect at the next edge. fieldwp >= BUF_SIZE is ignored.
- Field read: field_byte is registered with 1-cycle latency and reflects writes from the previous cycle. Read-during-write to the same byte returns the old value. fieldp >= BUF_SIZE returns 0.
- current_buffer is registered with 1-cycle latency from buffer_select and from active updates.
- Width rule: all index arithmetic is unsigned. The counter is $clog2(L+1) bits and never wraps past L.

Decomposition:
- Package pattern_pkg holds:
  - default parameters;
  - the serial FSM state enum;
  - a flat-index function byte_lsb(k) = k*BUF_WIDTH.
- Sub-module pattern_bank_entry (one per buffer, generate loop) holds the shadow chain, active array, copy and field write logic.
- The top level owns the FSM, counter, commit pending logic, output muxes and output registers.

Test Plan:
- Reset/defaults: assert reset 2 cycles during an active shift → all outputs 0; field reads of every buffer return 0; the next load needs a full L=96 shifts.
- Serial load + commit: shift 96 bits of pattern 0xA5,0x01..0x0B into buffer 3. load_done pulses on cycle 96. current_buffer for buffer_select=3 stays 0 until commit; commit_sel=3 → ack 1 cycle later, then current_buffer byte 11 = 0xA5.
- Deferred commit: commit buffer 5 at bit 40 of its load → no ack until load_done; ack in the cycle after load_done. A second commit meanwhile yields no extra ack.
- Field port: write 0x3C to buf 2 byte 7, then read the same → field_byte=0x3C one cycle after the read. Simultaneous read/write of the same byte returns the old value. fieldp=12 → 0.
- Collision: commit buffer 1 and field_write 0x77 to buffer 1 byte 0 in the same cycle → active byte 0 = 0x77, other bytes = shadow.
- saddr switch: change saddr 2→4 after 30 bits → load_done only after 96 further shifts to buffer 4; buffer 2 shadow keeps its 30 bits.
